// File: rtl/udp_tx_buf_pkg.sv
// Shared UDP definitions: frame marker, packet defaults
// and the one-hot transmit state encoding.
package udp_tx_buf_pkg;

    localparam logic [31:0] UDP_FRAME_HEAD = 32'hF3ED7A93;
    localparam int UDP_PKT_LEN  = 1024;
    localparam int UDP_FIFO_AW  = 11;
    localparam int UDP_FLUSH_TO = 256;
    localparam int UDP_GAP      = 16;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_SEND = 4'b0100,
        ST_GAP  = 4'b1000
    } udp_tx_state_e;

    function automatic logic [15:0] udp_pkt_bytes(
        input int unsigned occ_bytes,
        input int unsigned max_bytes
    );
        return 16'(occ_bytes < max_bytes ? occ_bytes : max_bytes);
    endfunction

endpackage

// File: rtl/udp_tx_fifo.sv
// 16-bit synchronous word FIFO with registered read data
// and an occupancy count; full is taken from registered count.
module udp_tx_fifo #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    output logic [15:0]   rd_data,
    output logic [AW:0]   count,
    output logic          full
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [15:0]   mem [2**AW];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (count == DEPTH);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & (count != '0);

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wr_data;
    end

    // pointers, occupancy and registered read port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) begin
                rp      <= rp + 1'b1;
                rd_data <= mem[rp];
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/udp_tx_buf.sv
// Video-to-UDP transmit buffer: frames pixels behind a head
// marker, packetises FIFO words into byte streams for the stack.
module udp_tx_buf
    import udp_tx_buf_pkg::*;
#(
    parameter logic [31:0] FRAME_HEAD = UDP_FRAME_HEAD,
    parameter int          PKT_LEN    = UDP_PKT_LEN,
    parameter int          FIFO_AW    = UDP_FIFO_AW,
    parameter int          FLUSH_TO   = UDP_FLUSH_TO,
    parameter int          GAP        = UDP_GAP
) (
    input  logic        app_tx_clk,
    input  logic        rstn,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [15:0] vid_data,
    output logic        app_tx_data_request,
    input  logic        app_tx_ack,
    output logic        app_tx_data_valid,
    output logic [7:0]  app_tx_data,
    output logic [15:0] app_tx_data_length,
    output logic        tx_overflow
);

    localparam int          IW       = $clog2(FLUSH_TO + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TO);

    udp_tx_state_e    state;
    udp_tx_state_e    state_nxt;
    logic [15:0]      cnt;
    logic [15:0]      len;
    logic             go;
    logic             head_pend;
    logic [IW-1:0]    idle_cnt;
    logic             wr_req;
    logic             wr_ok;
    logic [15:0]      wr_data;
    logic             rd_en;
    logic [15:0]      rd_data;
    logic [FIFO_AW:0] occ;
    logic             full;

    assign wr_req  = vid_vs | head_pend | vid_de;
    assign wr_ok   = wr_req & ~full;
    assign wr_data = vid_vs    ? FRAME_HEAD[31:16] :
                     head_pend ? FRAME_HEAD[15:0]  : vid_data;

    udp_tx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (app_tx_clk),
        .rstn    (rstn),
        .wr_en   (wr_req),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (occ),
        .full    (full)
    );

    // head sequencing, sticky drop flag and idle-write timer
    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            head_pend   <= 1'b0;
            tx_overflow <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            head_pend <= vid_vs;
            if ((vid_de & (vid_vs | head_pend)) | (wr_req & full))
                tx_overflow <= 1'b1;
            if (wr_ok)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // state register, per-state cycle counter, length latch
    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            len   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (go)
                len <= udp_pkt_bytes(32'({occ, 1'b0}), 32'(PKT_LEN));
        end
    end

    // next state and FIFO read strobe
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (32'(occ) >= PKT_LEN / 2 ||
                    (occ != '0 && idle_cnt == IDLE_MAX)) begin
                    go        = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (app_tx_ack) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                rd_en = (cnt == '0) || (!cnt[0] && cnt < len);
                if (cnt == len) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (cnt == 16'(GAP - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign app_tx_data_request = (state == ST_REQ);
    assign app_tx_data_valid   = (state == ST_SEND) && (cnt != '0);
    assign app_tx_data_length  = len;
    assign app_tx_data = !app_tx_data_valid ? 8'h00 :
                         cnt[0] ? rd_data[15:8] : rd_data[7:0];

endmodule
